// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the frame-counter width derivation.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;

  // A width-2 register still needs a 1-bit counter.
  function automatic int unsigned usr_cnt_width(input int unsigned data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shift operations and pulses frame_done for one cycle after every
// DATA_WIDTH-th shift since the last load or clear.
module shift_frame_counter
  import usr_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  localparam int CNT_WIDTH  = usr_cnt_width(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 shift_en,
  output logic [CNT_WIDTH-1:0] shift_cnt,
  output logic                 frame_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clr || load) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (shift_en) begin
      if (shift_cnt == CNT_LAST) begin
        shift_cnt  <= '0;
        frame_done <= 1'b1;
      end else begin
        shift_cnt  <= shift_cnt + 1'b1;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Width-generic shift/rotate/load register with a shift-frame counter;
// usable as serializer, deserializer or rotate-by-one stage.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  localparam int CNT_WIDTH  = usr_cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [2:0]            mode,
  input  logic                  sin_r,
  input  logic                  sin_l,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic [DATA_WIDTH-1:0] par_out,
  output logic                  sout_r,
  output logic                  sout_l,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  shift_cnt
);

  logic [DATA_WIDTH-1:0] q;
  logic                  shift_en;
  logic                  load;

  always_comb begin
    shift_en = 1'b0;
    load     = 1'b0;
    case (mode)
      MODE_SHR, MODE_SHL, MODE_ROTR, MODE_ROTL: shift_en = 1'b1;
      MODE_LOAD:                                load     = 1'b1;
      default:                                  ;
    endcase
  end

  // Reserved encodings fall through to default and hold q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_SHR:  q <= {sin_r, q[DATA_WIDTH-1:1]};
        MODE_SHL:  q <= {q[DATA_WIDTH-2:0], sin_l};
        MODE_LOAD: q <= par_in;
        MODE_ROTR: q <= {q[0], q[DATA_WIDTH-1:1]};
        MODE_ROTL: q <= {q[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
        default:   q <= q;
      endcase
    end
  end

  shift_frame_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_frame_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .shift_en  (shift_en),
    .shift_cnt (shift_cnt),
    .frame_done(frame_done)
  );

  assign par_out = q;
  assign sout_r  = q[0];
  assign sout_l  = q[DATA_WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: table-driven width-4 vectors through a scoreboard
// queue, async-reset checks, and a width 8/2 frame-pulse sweep.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [3:0] par_in4 = '0;
  logic [7:0] par_in8 = '0;
  logic [1:0] par_in2 = '0;

  logic [3:0] par_out4;
  logic       sout_r4, sout_l4, frame_done4;
  logic [1:0] shift_cnt4;
  logic [7:0] par_out8;
  logic       sout_r8, sout_l8, frame_done8;
  logic [2:0] shift_cnt8;
  logic [1:0] par_out2;
  logic       sout_r2, sout_l2, frame_done2;
  logic       shift_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .par_in(par_in4), .par_out(par_out4), .sout_r(sout_r4), .sout_l(sout_l4),
    .frame_done(frame_done4), .shift_cnt(shift_cnt4));

  universal_shift_register #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .par_in(par_in8), .par_out(par_out8), .sout_r(sout_r8), .sout_l(sout_l8),
    .frame_done(frame_done8), .shift_cnt(shift_cnt8));

  universal_shift_register #(.DATA_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .par_in(par_in2), .par_out(par_out2), .sout_r(sout_r2), .sout_l(sout_l2),
    .frame_done(frame_done2), .shift_cnt(shift_cnt2));

  typedef struct {
    logic       clr;
    logic [2:0] mode;
    logic       sr;
    logic       sl;
    logic [3:0] par;
    logic [3:0] q;
    logic [1:0] cnt;
    logic       done;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [1:0] cnt;
    logic       done;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic [2:0] m, input logic sr, input logic sl,
                              input logic [3:0] par, input logic [3:0] q, input logic [1:0] cnt,
                              input logic done);
    vec_t v;
    v.clr = c; v.mode = m; v.sr = sr; v.sl = sl; v.par = par;
    v.q = q; v.cnt = cnt; v.done = done;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    clr = v.clr; mode = v.mode; sin_r = v.sr; sin_l = v.sl; par_in4 = v.par;
    e.q = v.q; e.cnt = v.cnt; e.done = v.done; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d par_out", e.idx), 64'(par_out4), 64'(e.q));
      check($sformatf("v%0d sout_r", e.idx), 64'(sout_r4), 64'(e.q[0]));
      check($sformatf("v%0d sout_l", e.idx), 64'(sout_l4), 64'(e.q[3]));
      check($sformatf("v%0d shift_cnt", e.idx), 64'(shift_cnt4), 64'(e.cnt));
      check($sformatf("v%0d frame_done", e.idx), 64'(frame_done4), 64'(e.done));
    end
  endtask

  task automatic sweep_edge(input logic [2:0] m, input int step, inout int s);
    logic sh;
    @(negedge clk);
    clr = 1'b0; mode = m; sin_r = 1'b1;
    sh = (m == MODE_SHR);
    if (sh) s++;
    @(posedge clk);
    #1;
    check($sformatf("sweep%0d w8 frame_done", step), 64'(frame_done8), 64'(sh && (s % 8 == 0)));
    check($sformatf("sweep%0d w2 frame_done", step), 64'(frame_done2), 64'(sh && (s % 2 == 0)));
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr = 1'b1; mode = MODE_HOLD;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #3;
    check("reset par_out", 64'(par_out4), 64'h0);
    check("reset sout_r", 64'(sout_r4), 64'h0);
    check("reset sout_l", 64'(sout_l4), 64'h0);
    check("reset frame_done", 64'(frame_done4), 64'h0);
    check("reset shift_cnt", 64'(shift_cnt4), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // idle after reset
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // SISO: shift in 1,0,1,1 then drain with zeros
    add(1, MODE_SHR,  1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1000, 2'd1, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0100, 2'd2, 0);
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1010, 2'd3, 0);
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1101, 2'd0, 1);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0110, 2'd1, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0011, 2'd2, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0001, 2'd3, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0000, 2'd0, 1);
    // load and rotate
    add(0, MODE_LOAD, 0, 0, 4'b1001, 4'b1001, 2'd0, 0);
    add(0, MODE_ROTL, 0, 0, 4'b0000, 4'b0011, 2'd1, 0);
    add(0, MODE_ROTR, 0, 0, 4'b0000, 4'b1001, 2'd2, 0);
    add(0, MODE_ROTR, 0, 0, 4'b0000, 4'b1100, 2'd3, 0);
    // SHL deserialise
    add(0, MODE_LOAD, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, MODE_SHL,  0, 1, 4'b0000, 4'b0001, 2'd1, 0);
    add(0, MODE_SHL,  0, 1, 4'b0000, 4'b0011, 2'd2, 0);
    add(0, MODE_SHL,  0, 0, 4'b0000, 4'b0110, 2'd3, 0);
    add(0, MODE_SHL,  0, 1, 4'b0000, 4'b1101, 2'd0, 1);
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b1101, 2'd0, 0);
    // LOAD at the frame-completing position wins
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0110, 2'd1, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0011, 2'd2, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0001, 2'd3, 0);
    add(0, MODE_LOAD, 0, 0, 4'b0110, 4'b0110, 2'd0, 0);
    // clr beats SHR at the frame-completing position
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1011, 2'd1, 0);
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1101, 2'd2, 0);
    add(0, MODE_SHR,  1, 0, 4'b0000, 4'b1110, 2'd3, 0);
    add(1, MODE_SHR,  1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // reserved modes hold and do not count
    add(0, MODE_LOAD, 0, 0, 4'b1010, 4'b1010, 2'd0, 0);
    add(0, 3'b111,    1, 1, 4'b0101, 4'b1010, 2'd0, 0);
    add(0, 3'b110,    1, 1, 4'b0101, 4'b1010, 2'd0, 0);
    add(0, MODE_SHR,  0, 0, 4'b0000, 4'b0101, 2'd1, 0);
    add(0, 3'b111,    1, 1, 4'b1111, 4'b0101, 2'd1, 0);
    // mixed directions and a HOLD inside one frame
    add(0, MODE_SHL,  0, 1, 4'b0000, 4'b1011, 2'd2, 0);
    add(0, MODE_ROTR, 0, 0, 4'b0000, 4'b1101, 2'd3, 0);
    add(0, MODE_HOLD, 0, 0, 4'b0000, 4'b1101, 2'd3, 0);
    add(0, MODE_ROTL, 0, 0, 4'b0000, 4'b1011, 2'd0, 1);

    foreach (vecs[i]) apply(vecs[i], i);

    // asynchronous reset mid-cycle while frame_done and q are non-zero
    #2;
    rst = 1'b0;
    #1;
    check("async rst par_out", 64'(par_out4), 64'h0);
    check("async rst sout_l", 64'(sout_l4), 64'h0);
    check("async rst sout_r", 64'(sout_r4), 64'h0);
    check("async rst frame_done", 64'(frame_done4), 64'h0);
    check("async rst shift_cnt", 64'(shift_cnt4), 64'h0);
    @(negedge clk);
    mode = MODE_HOLD;
    rst = 1'b1;

    // width sweep: 16 continuous shifts
    clear_all();
    s = 0;
    for (int i = 1; i <= 16; i++) sweep_edge(MODE_SHR, i, s);
    check("w8 par_out", 64'(par_out8), 64'hff);
    check("w8 shift_cnt", 64'(shift_cnt8), 64'h0);
    check("w8 sout_r", 64'(sout_r8), 64'h1);
    check("w8 sout_l", 64'(sout_l8), 64'h1);
    check("w2 par_out", 64'(par_out2), 64'h3);
    check("w2 shift_cnt", 64'(shift_cnt2), 64'h0);
    check("w2 sout_r", 64'(sout_r2), 64'h1);
    check("w2 sout_l", 64'(sout_l2), 64'h1);

    // HOLD after shift 5 delays the width-8 pulse by one cycle
    clear_all();
    s = 0;
    for (int i = 1; i <= 12; i++) sweep_edge((i == 6) ? MODE_HOLD : MODE_SHR, 100 + i, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
